// File: rtl/tcp_vlg_rtx_sched.sv
// rtl/tcp_vlg_rtx_sched.sv - TCP retransmission scheduler (fast retransmit + RTO with backoff)
//
// Purpose:
//   Decides when, and from which sequence number, the transmit path must
//   resend unacknowledged data. Two triggers feed it: a rising edge of the
//   duplicate-ACK detector output (fast retransmit, once per ACK advance) and
//   an RTO timer counted in tick strobes with exponential backoff. One request
//   at a time is handed to the TX path over rtx_req/rtx_ack.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   connected       connection established
//   loc_seq         next local sequence number to send
//   rem_ack         highest acknowledgment received
//   dup_det         duplicate-ACK threshold level from the detector
//   dup_ack         sequence number reported as duplicated
//   tick            single-cycle timebase strobe
//   rtx_req         retransmit request (registered)
//   rtx_seq         retransmit start sequence, stable while rtx_req=1
//   rtx_fast        1: fast retransmit, 0: timeout retransmit
//   rtx_ack         TX path accepted the request
//   rtx_fail        retransmit limit exhausted, abort the connection
//   backoff         current backoff exponent

module tcp_vlg_rtx_sched #(
  parameter int unsigned RTO_TICKS   = 1000,
  parameter int unsigned MAX_BACKOFF = 6,
  parameter int unsigned MAX_RTX     = 8,
  parameter int unsigned VERBOSE     = 0,
  parameter              DUT_STRING  = ""
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               connected,
  input  logic [31:0]                        loc_seq,
  input  logic [31:0]                        rem_ack,
  input  logic                               dup_det,
  input  logic [31:0]                        dup_ack,
  input  logic                               tick,
  output logic                               rtx_req,
  output logic [31:0]                        rtx_seq,
  output logic                               rtx_fast,
  input  logic                               rtx_ack,
  output logic                               rtx_fail,
  output logic [$clog2(MAX_BACKOFF+1)-1:0]   backoff
);

  localparam int BW = $clog2(MAX_BACKOFF + 1);
  localparam int CW = $clog2(MAX_RTX + 1);
  localparam int TW = $clog2(RTO_TICKS << MAX_BACKOFF) + 1;

  // Message hooks are simulation-only; nothing is generated in hardware.
  if ((VERBOSE != 0) && ($bits(DUT_STRING) > 0)) begin : g_verbose
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_REQ   = 2'd2,
    S_FAIL  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [BW-1:0]   backoff_nxt;
  logic [CW-1:0]   rtx_cnt, cnt_nxt;
  logic            fast_lock, lock_nxt;
  logic [31:0]     seq_nxt;
  logic            fast_nxt;
  logic [31:0]     ack_q;
  logic            dup_q;

  logic            outstanding;
  logic            new_ack;
  logic            dup_edge;
  logic [TW-1:0]   rto_lim;
  logic            timeout;

  assign outstanding = connected && (loc_seq != rem_ack);
  assign new_ack     = (rem_ack != ack_q);
  assign dup_edge    = dup_det && !dup_q;

  // Current timeout is RTO_TICKS << backoff; the timer never passes
  // rto_lim-1 because the timeout tick clears it.
  assign rto_lim = TW'(RTO_TICKS) << backoff;
  assign timeout = tick && (timer == (rto_lim - TW'(1)));

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    backoff_nxt = backoff;
    cnt_nxt     = rtx_cnt;
    lock_nxt    = fast_lock;
    seq_nxt     = rtx_seq;
    fast_nxt    = rtx_fast;

    case (state)
      S_IDLE: begin
        if (outstanding) begin
          state_nxt   = S_ARMED;
          timer_nxt   = '0;
          backoff_nxt = '0;
          cnt_nxt     = '0;
          lock_nxt    = 1'b0;
        end
      end

      S_ARMED: begin
        if (!outstanding) begin
          state_nxt   = S_IDLE;
          timer_nxt   = '0;
          backoff_nxt = '0;
          cnt_nxt     = '0;
          lock_nxt    = 1'b0;
        end else if (new_ack) begin
          // ACK progress restarts the whole RTO schedule and re-enables
          // fast retransmit; any coincident timeout or dup edge is dropped.
          timer_nxt   = '0;
          backoff_nxt = '0;
          cnt_nxt     = '0;
          lock_nxt    = 1'b0;
        end else if (timeout) begin
          timer_nxt = '0;
          if (rtx_cnt == CW'(MAX_RTX)) begin
            state_nxt = S_FAIL;
          end else begin
            state_nxt   = S_REQ;
            seq_nxt     = rem_ack;
            fast_nxt    = 1'b0;
            backoff_nxt = (backoff == BW'(MAX_BACKOFF)) ? backoff : backoff + BW'(1);
            cnt_nxt     = rtx_cnt + CW'(1);
            // A dup edge swallowed by the timeout still consumes the
            // fast retransmit for this ACK value.
            if (dup_edge) begin
              lock_nxt = 1'b1;
            end
          end
        end else if (dup_edge && !fast_lock) begin
          state_nxt = S_REQ;
          seq_nxt   = dup_ack;
          fast_nxt  = 1'b1;
          lock_nxt  = 1'b1;
        end else if (tick) begin
          timer_nxt = timer + TW'(1);
        end
      end

      S_REQ: begin
        if (!outstanding) begin
          // Only legal withdrawal of a pending request.
          state_nxt   = S_IDLE;
          timer_nxt   = '0;
          backoff_nxt = '0;
          cnt_nxt     = '0;
          lock_nxt    = 1'b0;
        end else if (rtx_ack) begin
          state_nxt = S_ARMED;
          timer_nxt = '0;
        end
      end

      S_FAIL: begin
        if (!connected) begin
          state_nxt   = S_IDLE;
          timer_nxt   = '0;
          backoff_nxt = '0;
          cnt_nxt     = '0;
          lock_nxt    = 1'b0;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      backoff   <= '0;
      rtx_cnt   <= '0;
      fast_lock <= 1'b0;
      rtx_seq   <= '0;
      rtx_fast  <= 1'b0;
      rtx_req   <= 1'b0;
      rtx_fail  <= 1'b0;
      ack_q     <= '0;
      dup_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      backoff   <= backoff_nxt;
      rtx_cnt   <= cnt_nxt;
      fast_lock <= lock_nxt;
      rtx_seq   <= seq_nxt;
      rtx_fast  <= fast_nxt;
      rtx_req   <= (state_nxt == S_REQ);
      rtx_fail  <= (state_nxt == S_FAIL);
      ack_q     <= rem_ack;
      dup_q     <= dup_det;
    end
  end

endmodule

// File: doc/tcp_vlg_rtx_sched.md
# tcp_vlg_rtx_sched

Retransmission scheduler for the TCP engine. Decides when and from which sequence number the transmit path must resend unacknowledged data. It combines two triggers: the duplicate-ACK detector's fast-retransmit indication and an RTO timer with exponential backoff. It sits between the fast-retransmit detector and the TX queue/segment builder, and hands out one retransmit request at a time over a req/ack handshake.

## Interface
- RTO_TICKS, 1000: base retransmission timeout in `tick` strobes.
- MAX_BACKOFF, 6: maximum backoff exponent; timeout = RTO_TICKS << backoff.
- MAX_RTX, 8: consecutive timeout retransmissions allowed before abort.
- VERBOSE, 0: simulation-only messages.
- DUT_STRING, "": prefix for simulation messages.

- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- connected  in  1  connection in established state
- loc_seq  in  32  next local sequence number to send
- rem_ack  in  32  highest acknowledgment received from the remote
- dup_det  in  1  duplicate-ACK threshold reached (level from the detector)
- dup_ack  in  32  sequence number reported as duplicated
- tick  in  1  single-cycle timebase strobe
- rtx_req  out  1  retransmit request
- rtx_seq  out  32  sequence number to retransmit from, stable while rtx_req=1
- rtx_fast  out  1  request caused by a fast retransmit (1) or a timeout (0)
- rtx_ack  in  1  TX path accepted the request
- rtx_fail  out  1  retransmit limit exhausted; connection must be aborted
- backoff  out  $clog2(MAX_BACKOFF+1)  current backoff exponent

## Operation
- outstanding = connected && (loc_seq != rem_ack).
- The block keeps a registered copy `ack_q` of rem_ack. new_ack = (rem_ack != ack_q).
- States:
  - IDLE: no data outstanding.
  - ARMED: timer running.
  - REQ: request pending.
  - FAIL: limit reached.
- IDLE -> ARMED when outstanding. On entry: timer=0, backoff=0, rtx_cnt=0, fast_lock=0.
- ARMED:
  - Timer increments on each `tick`.
  - new_ack clears the timer, backoff, rtx_cnt and fast_lock, and suppresses every other event in that cycle.
  - Timeout means `tick` while timer == (RTO_TICKS<<backoff)-1.
    - If rtx_cnt == MAX_RTX, go to FAIL.
    - Otherwise go to REQ with rtx_seq=rem_ack and rtx_fast=0. Backoff increments, saturating at MAX_BACKOFF. rtx_cnt increments.
  - A rising edge of dup_det with fast_lock=0 goes to REQ with rtx_seq=dup_ack and rtx_fast=1, and sets fast_lock.
  - If timeout and a dup_det edge occur in the same cycle, timeout wins and fast_lock is set.
- REQ:
  - rtx_req=1 and rtx_seq/rtx_fast are held stable.
  - On rtx_ack: go to ARMED with timer=0. Backoff and rtx_cnt are kept.
  - A dup_det edge while in REQ is ignored.
- From IDLE, ARMED or REQ: !outstanding forces IDLE at the next edge. A pending rtx_req drops without rtx_ack. This is the only permitted withdrawal of a request.
- FAIL: rtx_fail=1 and rtx_req=0. Exit to IDLE only on rst or when connected=0.
- Timer width: $clog2(RTO_TICKS<<MAX_BACKOFF)+1 bits. The timer never wraps; it is compared and cleared only.

## Timing
- Reset values: state=IDLE, rtx_req=0, rtx_seq=0, rtx_fast=0, rtx_fail=0, backoff=0, timer=0, rtx_cnt=0, fast_lock=0, ack_q=0.
- rst takes effect at the next edge from any state, including mid-REQ. Outputs are at their reset values the following cycle.
- All outputs are registered.
- dup_det edge sampled in cycle N gives rtx_req=1 in cycle N+1.
- Timeout tick in cycle N gives rtx_req=1 in cycle N+1.
- The backoff output updates in the same cycle rtx_req rises.
- The rtx_ack cycle is the last cycle of rtx_req=1. rtx_req is 0 in the next cycle.
- rtx_ack is ignored when rtx_req=0.
- Back-to-back rtx_req cannot occur: a new request needs at least one cycle in ARMED.
- rtx_fail rises one cycle after the final timeout tick.

## Test plan
- Timeout path. Setup: RTO_TICKS=4, tick every cycle, loc_seq=1000, rem_ack=500. Expected: rtx_req rises after the 4th tick with rtx_seq=500, rtx_fast=0, backoff=1. After rtx_ack, the next request comes 8 ticks later with backoff=2.
- Fast path. Stimulus: dup_det rises with dup_ack=700. Expected: rtx_req=1 the next cycle, rtx_seq=700, rtx_fast=1. A second dup_det pulse after rtx_ack produces no request until rem_ack changes to 800; a dup_det after that change is honoured.
- Backoff and limit. Setup: MAX_BACKOFF=2, MAX_RTX=3, RTO_TICKS=4, no ACKs, every request acked immediately. Expected: intervals of 4, 8 and 16 ticks with backoff 1, 2, 2; the 4th timeout raises rtx_fail with no rtx_req. Dropping connected returns the block to IDLE with rtx_fail=0.
- Withdrawal. Stimulus: while rtx_req=1 with no rtx_ack, rem_ack jumps to loc_seq=1000. Expected: rtx_req=0 the next cycle, state IDLE, backoff=0.
- Collision. Stimulus: timeout tick and dup_det edge (dup_ack=600) in the same cycle, rem_ack=500. Expected: rtx_seq=500, rtx_fast=0, and a later dup_det is ignored. Separately, new_ack coinciding with a timeout produces no request and resets the timer.
- Reset. Stimulus: rst asserted for one cycle during REQ. Expected: all outputs 0 the next cycle, state IDLE. The block re-arms when outstanding is still true after rst deasserts.
